// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes ADD/SUB-class instructions into ALU operands and
// buffers them in a two-entry (main + skid) elastic stage toward the execute unit.

package riscv_pkg;
    typedef enum logic [0:0] {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } ALU_ctrl;
endpackage

module alu_issue_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output ALU_ctrl     ALUop,
    output logic        illegal
);

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        ALU_ctrl     aluop;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    localparam entry_t ResetEntry = '{op1: 32'd0, op2: 32'd0, aluop: ALU_ADD, illegal: 1'b0};

    state_e      r_state;
    state_e      w_state_next;
    entry_t      r_main;
    entry_t      r_skid;
    entry_t      w_dec;
    logic        r_in_ready;
    logic        w_accept;
    logic        w_pop;
    logic        w_load_main;
    logic        w_load_skid;
    logic        w_main_from_skid;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_u  = {instr[31:12], 12'd0};

    // Anything not explicitly recognised falls through as an illegal, zero-operand ADD.
    always_comb begin
        w_dec = '{op1: 32'd0, op2: 32'd0, aluop: ALU_ADD, illegal: 1'b1};
        case (w_opcode)
            7'b0110011: begin
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
                    w_dec = '{op1: rs1_data, op2: rs2_data, aluop: ALU_ADD, illegal: 1'b0};
                end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
                    w_dec = '{op1: rs1_data, op2: rs2_data, aluop: ALU_SUB, illegal: 1'b0};
                end
            end
            7'b0010011: begin
                if (w_funct3 == 3'b000) begin
                    w_dec = '{op1: rs1_data, op2: w_imm_i, aluop: ALU_ADD, illegal: 1'b0};
                end
            end
            7'b0000011: w_dec = '{op1: rs1_data, op2: w_imm_i, aluop: ALU_ADD, illegal: 1'b0};
            7'b0100011: w_dec = '{op1: rs1_data, op2: w_imm_s, aluop: ALU_ADD, illegal: 1'b0};
            7'b1100011: w_dec = '{op1: rs1_data, op2: rs2_data, aluop: ALU_SUB, illegal: 1'b0};
            7'b0110111: w_dec = '{op1: 32'd0, op2: w_imm_u, aluop: ALU_ADD, illegal: 1'b0};
            7'b0010111: w_dec = '{op1: pc, op2: w_imm_u, aluop: ALU_ADD, illegal: 1'b0};
            default:    w_dec = '{op1: 32'd0, op2: 32'd0, aluop: ALU_ADD, illegal: 1'b1};
        endcase
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != StFull);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = StEmpty;
        end else begin
            case (r_state)
                StEmpty: if (w_accept) w_state_next = StOne;
                StOne: begin
                    if (w_accept && !w_pop) begin
                        w_state_next = StFull;
                    end else if (!w_accept && w_pop) begin
                        w_state_next = StEmpty;
                    end
                end
                StFull:  if (w_pop) w_state_next = StOne;
                default: w_state_next = StEmpty;
            endcase
        end
    end

    always_comb begin
        out_valid        = (r_state != StEmpty);
        in_ready         = r_in_ready;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (!flush) begin
            case (r_state)
                StEmpty: w_load_main = w_accept;
                StOne: begin
                    w_load_main = w_accept & w_pop;
                    w_load_skid = w_accept & ~w_pop;
                end
                StFull:  w_main_from_skid = w_pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= ResetEntry;
            r_skid <= ResetEntry;
        end else begin
            if (w_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_load_main) begin
                r_main <= w_dec;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign op1     = r_main.op1;
    assign op2     = r_main.op2;
    assign ALUop   = r_main.aluop;
    assign illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by random traffic,
// compared against a queue-based reference of the two-entry issue buffer.

module tb_alu_issue_stage;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sub;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    ALU_ctrl     ALUop;
    logic        illegal;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t model_q[$];

    alu_issue_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op1       (op1),
        .op2       (op2),
        .ALUop     (ALUop),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // What the ALU should be handed for one instruction, straight from the ISA rules.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] p);
        exp_t e;
        logic [11:0] i_imm;
        logic [11:0] s_imm;
        i_imm = w[31:20];
        s_imm = {w[31:25], w[11:7]};
        e = '{op1: 32'd0, op2: 32'd0, sub: 1'b0, ill: 1'b1};
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00)
            e = '{op1: a, op2: b, sub: 1'b0, ill: 1'b0};
        else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20)
            e = '{op1: a, op2: b, sub: 1'b1, ill: 1'b0};
        else if ((w[6:0] == 7'h13 && w[14:12] == 3'd0) || w[6:0] == 7'h03)
            e = '{op1: a, op2: 32'($signed(i_imm)), sub: 1'b0, ill: 1'b0};
        else if (w[6:0] == 7'h23)
            e = '{op1: a, op2: 32'($signed(s_imm)), sub: 1'b0, ill: 1'b0};
        else if (w[6:0] == 7'h63)
            e = '{op1: a, op2: b, sub: 1'b1, ill: 1'b0};
        else if (w[6:0] == 7'h37)
            e = '{op1: 32'd0, op2: w & 32'hFFFF_F000, sub: 1'b0, ill: 1'b0};
        else if (w[6:0] == 7'h17)
            e = '{op1: p, op2: w & 32'hFFFF_F000, sub: 1'b0, ill: 1'b0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        if (model_q.size() != 0) begin
            chk("op1", op1, model_q[0].op1);
            chk("op2", op2, model_q[0].op2);
            chk("aluop", 32'(ALUop), {31'd0, model_q[0].sub});
            chk("illegal", {31'd0, illegal}, {31'd0, model_q[0].ill});
        end
    endtask

    // One clock: drive, check what is presented now, advance the model, move past the edge.
    task automatic cycle(input logic iv, input logic [31:0] w, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy,
                         input logic fl);
        logic acc;
        logic pop;
        in_valid  = iv;
        instr     = w;
        pc        = p;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        chk_model();
        acc = iv && (model_q.size() < 2);
        pop = ordy && (model_q.size() != 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(w, a, b, p));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_op1"}, op1, 32'd0);
        chk({tag, "_op2"}, op2, 32'd0);
        chk({tag, "_aluop"}, 32'(ALUop), 32'd0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  bad_ops[3];
        bad_ops = '{7'h6F, 7'h0F, 7'h7F};
        r = $urandom();
        case ($urandom_range(0, 9))
            0: return {7'h00, r[24:15], 3'd0, r[11:7], 7'h33};
            1: return {7'h20, r[24:15], 3'd0, r[11:7], 7'h33};
            2: return {7'h01, r[24:15], 3'd0, r[11:7], 7'h33};
            3: return {r[31:15], 3'd0, r[11:7], 7'h13};
            4: return {r[31:15], 3'd2, r[11:7], 7'h03};
            5: return {r[31:15], 3'd2, r[11:7], 7'h23};
            6: return {r[31:15], 3'd0, r[11:7], 7'h63};
            7: return {r[31:7], 7'h37};
            8: return {r[31:7], 7'h17};
            default: return {r[31:7], bad_ops[$urandom_range(0, 2)]};
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'd0;
        pc        = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add x3,x1,x2 visible the cycle after acceptance
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_op1", op1, 32'd5);
        chk("add_op2", op2, 32'd7);
        chk("add_aluop", 32'(ALUop), 32'(ALU_ADD));
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // sub then beq with the consumer stalled: fill to full and hold
        cycle(1'b1, 32'h4020_81B3, 32'h0, 32'd9, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_8463, 32'h0, 32'd3, 32'd3, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_op1", op1, 32'd9);
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("hold_op1", op1, 32'd9);
        chk("hold_aluop", 32'(ALUop), 32'(ALU_SUB));
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("beq_op1", op1, 32'd3);
        chk("beq_aluop", 32'(ALUop), 32'(ALU_SUB));
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // lui / auipc / addi -1 / illegal opcode
        cycle(1'b1, 32'h1234_52B7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        chk("lui_op1", op1, 32'd0);
        chk("lui_op2", op2, 32'h1234_5000);
        cycle(1'b1, 32'h1234_5297, 32'h100, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        chk("auipc_op1", op1, 32'h100);
        chk("auipc_op2", op2, 32'h1234_5000);
        cycle(1'b1, 32'hFFF0_0093, 32'h0, 32'd1, 32'd0, 1'b1, 1'b0);
        chk("addi_op2", op2, 32'hFFFF_FFFF);
        chk("addi_aluop", 32'(ALUop), 32'(ALU_ADD));
        cycle(1'b1, 32'h0000_007F, 32'h40, 32'd3, 32'd4, 1'b1, 1'b0);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_op1", op1, 32'd0);
        chk("ill_op2", op2, 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // flush while full, with a same-cycle input that must be dropped
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h4020_81B3, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd11, 32'd12, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

        // asynchronous reset pulse while full
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd13, 32'd14, 1'b0, 1'b0);
        cycle(1'b1, 32'h4020_81B3, 32'h0, 32'd15, 32'd16, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_reset_values("midrst");
        model_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0020_81B3, 32'h0, 32'd21, 32'd22, 1'b1, 1'b0);
        chk("post_rst_op1", op1, 32'd21);

        // random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 70, rand_instr(), $urandom(), $urandom(), $urandom(),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
        end
        chk_model();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  stage can accept; high iff fewer than 2 entries held.
REQ-006 instr  input  32  raw RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 rs1_data, rs2_data  input  32 each  register-file read values.
REQ-009 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-010 out_valid  output  1  entry presented to the ALU.
REQ-011 out_ready  input  1  execute stage consumes the entry.
REQ-012 op1, op2  output  32 each  ALU operands.
REQ-013 ALUop  output  ALU_ctrl (riscv_pkg)  ALU_ADD or ALU_SUB.
REQ-014 illegal  output  1  the presented entry is an unsupported opcode.

Function
REQ-015 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-016 Storage SHALL be a main register driving the outputs plus one skid register; states EMPTY, ONE, FULL.
REQ-017 Decode at input time (combinational on instr), registered into the entry:
 - R-type 0110011: funct3=000, funct7=0000000 -> ADD; funct7=0100000 -> SUB; op1=rs1, op2=rs2.
 - 0010011 funct3=000 (addi), 0000011 (lw) -> ADD; op1=rs1, op2=sext I-imm.
 - 0100011 (sw) -> ADD; op1=rs1, op2=sext S-imm.
 - 1100011 (beq) -> SUB; op1=rs1, op2=rs2.
 - 0110111 (lui) -> ADD; op1=0, op2={instr[31:12],12'b0}.
 - 0010111 (auipc) -> ADD; op1=pc, op2=U-imm.
 - any other encoding -> illegal=1, ALUop=ALU_ADD, op1=op2=0.
REQ-018 Latency: an instruction accepted in EMPTY SHALL appear on outputs the next cycle.
REQ-019 EMPTY + accept -> ONE.
REQ-020 ONE + accept + pop -> ONE, main loaded with new entry.
REQ-021 ONE + accept, no pop -> FULL, new entry into skid, outputs unchanged.
REQ-022 ONE + pop, no accept -> EMPTY.
REQ-023 FULL + pop -> ONE, skid moved to main; in_ready=0 in FULL so no accept.
REQ-024 Entries SHALL leave in acceptance order; none dropped or duplicated.
REQ-025 While out_valid=1 and out_ready=0, op1/op2/ALUop/illegal SHALL remain stable.
REQ-026 in_ready SHALL be a registered function of state (no combinational path from out_ready).
REQ-027 flush=1 SHALL take priority: next state EMPTY, any same-cycle input dropped, out_valid=0 next cycle.
REQ-028 Operand arithmetic is modulo 2^32; immediates sign-extended from bit 31.

Reset
REQ-029 rst_n low SHALL immediately force EMPTY: out_valid=0, in_ready=1, op1=op2=0, ALUop=ALU_ADD, illegal=0.
REQ-030 Reset asserted mid-operation SHALL discard all held entries; after release first accept behaves as from EMPTY.

Verification
REQ-031 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, ALUop=ALU_ADD.
REQ-032 sub (0x402081B3) then beq (0x00208463) back-to-back, out_ready=0 -> FULL, in_ready=0, outputs hold sub; raise out_ready -> sub then beq, both ALU_SUB.
REQ-033 lui x5,0x12345 (0x123452B7) -> op1=0, op2=0x12345000; auipc with pc=0x100 same imm -> op1=0x100.
REQ-034 addi with imm=-1 (0xFFF00093), rs1=1 -> op2=0xFFFFFFFF, ALUop=ALU_ADD.
REQ-035 instr=0x0000007F -> illegal=1, op1=op2=0; FULL then flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-036 rst_n pulsed low while FULL -> outputs at reset values immediately, no stale entry after release.
